// File: rtl/multi_cycle_control_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
//  Shared constants for the multi-cycle CPU sequencer:
//   - FSM state encodings (S_*), also shown on the debug display;
//   - instruction opcodes (OP_*);
//   - ALU operation codes (ALU_*);
//   - RegDst and PCSrc select codes;
//   - the one-hot opcode class record produced by mc_opclass;
//   - alu_op_of(): opcode -> ALU operation.
// -----------------------------------------------------------------------------
package mc_pkg;

   localparam int OPW    = 6;
   localparam int ALUOPW = 3;

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b111
   } state_t;

   localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
   localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
   localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
   localparam logic [OPW-1:0] OP_AND   = 6'b010000;
   localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
   localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
   localparam logic [OPW-1:0] OP_XORI  = 6'b010011;
   localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
   localparam logic [OPW-1:0] OP_SLTI  = 6'b100110;
   localparam logic [OPW-1:0] OP_SLT   = 6'b100111;
   localparam logic [OPW-1:0] OP_SW    = 6'b110000;
   localparam logic [OPW-1:0] OP_LW    = 6'b110001;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
   localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
   localparam logic [OPW-1:0] OP_BLTZ  = 6'b110110;
   localparam logic [OPW-1:0] OP_J     = 6'b111000;
   localparam logic [OPW-1:0] OP_JR    = 6'b111001;
   localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
   localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

   localparam logic [ALUOPW-1:0] ALU_ADD  = 3'b000;
   localparam logic [ALUOPW-1:0] ALU_SUB  = 3'b001;
   localparam logic [ALUOPW-1:0] ALU_SLL  = 3'b010;   // B << A
   localparam logic [ALUOPW-1:0] ALU_OR   = 3'b011;
   localparam logic [ALUOPW-1:0] ALU_AND  = 3'b100;
   localparam logic [ALUOPW-1:0] ALU_SLTU = 3'b101;
   localparam logic [ALUOPW-1:0] ALU_SLT  = 3'b110;
   localparam logic [ALUOPW-1:0] ALU_XOR  = 3'b111;

   localparam logic [1:0] RD_R31 = 2'b00;   // link register
   localparam logic [1:0] RD_RT  = 2'b01;
   localparam logic [1:0] RD_RD  = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;   // PC+4
   localparam logic [1:0] PC_BR  = 2'b01;   // PC+4+(imm<<2)
   localparam logic [1:0] PC_RS  = 2'b10;   // register jump
   localparam logic [1:0] PC_JMP = 2'b11;   // absolute jump target

   typedef struct packed {
      logic rtype;
      logic ialu;
      logic load;
      logic store;
      logic branch;
      logic jump;
      logic halt;
      logic illegal;
   } op_class_t;

   function automatic logic [ALUOPW-1:0] alu_op_of(input logic [OPW-1:0] op);
      logic [ALUOPW-1:0] res;
      case (op)
         OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: res = ALU_SUB;   // branches compare by subtraction
         OP_AND, OP_ANDI:                 res = ALU_AND;
         OP_ORI:                          res = ALU_OR;
         OP_XORI:                         res = ALU_XOR;
         OP_SLL:                          res = ALU_SLL;
         OP_SLT, OP_SLTI:                 res = ALU_SLT;
         default:                         res = ALU_ADD;   // add/addiu and lw/sw address
      endcase
      return res;
   endfunction

endpackage

// File: rtl/multi_cycle_control_opclass.sv
// -----------------------------------------------------------------------------
// mc_opclass
//  Combinational opcode classifier. Exactly one bit of op_class is set.
//  Ports:
//   opcode   in   OPW  opcode from the instruction register
//   op_class out  8    one-hot {rtype, ialu, load, store, branch, jump, halt, illegal}
// -----------------------------------------------------------------------------
module mc_opclass
   import mc_pkg::*;
(
   input  logic [OPW-1:0] opcode,
   output op_class_t      op_class
);

   always_comb begin
      op_class = '0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT:       op_class.rtype   = 1'b1;
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:  op_class.ialu    = 1'b1;
         OP_LW:                                        op_class.load    = 1'b1;
         OP_SW:                                        op_class.store   = 1'b1;
         OP_BEQ, OP_BNE, OP_BLTZ:                      op_class.branch  = 1'b1;
         OP_J, OP_JR, OP_JAL:                          op_class.jump    = 1'b1;
         OP_HALT:                                      op_class.halt    = 1'b1;
         default:                                      op_class.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// -----------------------------------------------------------------------------
// multi_cycle_control
//  IF/ID/EXE/MEM/WB sequencer for the multi-cycle CPU datapath. The state
//  register is the only storage; every output is a combinational decode of
//  the state, the opcode and the ALU flags.
//  Optional feature macro: CU_STALL_EN -- adds mem_ready and holds S_MEM
//  while the data memory is not ready.
//  Ports:
//   CLK        in   1  clock, rising edge
//   Reset      in   1  asynchronous active-low reset
//   Opcode     in   6  opcode, stable from ID onward
//   zero/sign  in   1  ALU flags, used to resolve branches in EXE
//   mem_ready  in   1  data memory ready (CU_STALL_EN only)
//   PCWre, IRWre, RegWre          out  load/write strobes
//   RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, ALUOp, DBDataSrc, PCSrc
//                                 out  datapath selects
//   nRD, nWR   out  1  data memory read/write, active low
//   state      out  3  current state for the debug display
// -----------------------------------------------------------------------------
module multi_cycle_control
   import mc_pkg::*;
(
   input  logic              CLK,
   input  logic              Reset,
   input  logic [OPW-1:0]    Opcode,
   input  logic              zero,
   input  logic              sign,
`ifdef CU_STALL_EN
   input  logic              mem_ready,
`endif
   output logic              PCWre,
   output logic              IRWre,
   output logic              RegWre,
   output logic [1:0]        RegDst,
   output logic              WrRegDSrc,
   output logic              ALUSrcA,
   output logic              ALUSrcB,
   output logic              ExtSel,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              nRD,
   output logic              nWR,
   output logic              DBDataSrc,
   output logic [1:0]        PCSrc,
   output logic [2:0]        state
);

   state_t    state_q, state_d;
   op_class_t cls;
   logic      mem_go;
   logic      is_jal, is_j, is_jr, is_sll, sext_op, br_taken;

   mc_opclass u_opclass (
      .opcode   (Opcode),
      .op_class (cls)
   );

`ifdef CU_STALL_EN
   assign mem_go = mem_ready;
`else
   assign mem_go = 1'b1;
`endif

   assign is_jal  = (Opcode == OP_JAL);
   assign is_j    = (Opcode == OP_J);
   assign is_jr   = (Opcode == OP_JR);
   assign is_sll  = (Opcode == OP_SLL);
   assign sext_op = (Opcode == OP_ADDIU) || (Opcode == OP_SLTI) ||
                    cls.load || cls.store || cls.branch;

   always_comb begin
      br_taken = 1'b0;
      case (Opcode)
         OP_BEQ:  br_taken = zero;
         OP_BNE:  br_taken = ~zero;
         OP_BLTZ: br_taken = sign;
         default: br_taken = 1'b0;
      endcase
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:   state_d = S_ID;
         S_ID: begin
            if (cls.halt)
               state_d = S_HALT;
            else if (cls.jump || cls.illegal)   // unknown opcodes retire as a NOP
               state_d = S_IF;
            else
               state_d = S_EXE;
         end
         S_EXE: begin
            if (cls.branch)
               state_d = S_IF;
            else if (cls.load || cls.store)
               state_d = S_MEM;
            else
               state_d = S_WB;
         end
         S_MEM: begin
            if (mem_go)
               state_d = cls.load ? S_WB : S_IF;
         end
         S_WB:   state_d = S_IF;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
         state_q <= S_IF;
      else
         state_q <= state_d;
   end

   // Output decode. While Reset is low everything is forced to its idle value,
   // otherwise selects follow the opcode for the whole instruction and strobes
   // follow the state.
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      RegDst    = RD_R31;
      WrRegDSrc = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = ALU_ADD;
      nRD       = 1'b1;
      nWR       = 1'b1;
      DBDataSrc = 1'b0;
      PCSrc     = PC_SEQ;
      if (Reset) begin
         if (cls.rtype)
            RegDst = RD_RD;
         else if (cls.ialu || cls.load)
            RegDst = RD_RT;
         WrRegDSrc = ~is_jal;               // jal writes the return address
         ALUSrcA   = is_sll;
         ALUSrcB   = cls.ialu || cls.load || cls.store;
         ExtSel    = sext_op;
         ALUOp     = alu_op_of(Opcode);
         DBDataSrc = cls.load;
         if (is_j || is_jal)
            PCSrc = PC_JMP;
         else if (is_jr)
            PCSrc = PC_RS;
         else if (cls.branch && (state_q == S_EXE) && br_taken)
            PCSrc = PC_BR;

         IRWre  = (state_q == S_IF);
         // The last state of an instruction is the one returning to IF; this
         // also keeps PCWre low while S_MEM is stalled and in S_HALT.
         PCWre  = (state_d == S_IF);
         RegWre = (state_q == S_WB) || ((state_q == S_ID) && is_jal);
         nRD    = ~((state_q == S_MEM) && cls.load);
         nWR    = ~((state_q == S_MEM) && cls.store);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
`timescale 1ns/1ps
module tb_multi_cycle_control;

   logic       CLK, Reset, zero, sign;
   logic [5:0] Opcode;
`ifdef CU_STALL_EN
   logic       mem_ready;
`endif
   logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
   logic       nRD, nWR, DBDataSrc;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp, state;

   multi_cycle_control dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Opcode    (Opcode),
      .zero      (zero),
      .sign      (sign),
`ifdef CU_STALL_EN
      .mem_ready (mem_ready),
`endif
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .RegWre    (RegWre),
      .RegDst    (RegDst),
      .WrRegDSrc (WrRegDSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ExtSel    (ExtSel),
      .ALUOp     (ALUOp),
      .nRD       (nRD),
      .nWR       (nWR),
      .DBDataSrc (DBDataSrc),
      .PCSrc     (PCSrc),
      .state     (state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Per-cycle expectation held in the scoreboard
   typedef struct {
      logic [2:0] state;
      logic       pcwre, irwre, regwre, nrd, nwr;
      logic       chk_sel;
      logic [1:0] regdst;
      logic       wrsrc, srca, srcb, ext;
      logic [2:0] aluop;
      logic       dbsrc;
      logic       chk_pc;
      logic [1:0] pcsrc;
      int         tag;
   } exp_t;

   // One instruction: state sequence (3 bits per cycle), per-cycle strobe masks, selects
   typedef struct {
      logic [5:0]  op;
      logic        z, s;
      int          lat;
      logic [14:0] st;
      logic [4:0]  rw, rd, wr;
      logic [1:0]  regdst;
      logic        wrsrc, srca, srcb, ext;
      logic [2:0]  aluop;
      logic        dbsrc;
      logic [1:0]  pcsrc;
   } vec_t;

   localparam logic [14:0] ST_ALU = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
   localparam logic [14:0] ST_LW  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
   localparam logic [14:0] ST_SW  = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
   localparam logic [14:0] ST_BR  = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
   localparam logic [14:0] ST_J   = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};

   exp_t sb[$];
   vec_t vecs[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic [5:0] op, input logic z, input logic s,
                               input int lat, input logic [14:0] st,
                               input logic [4:0] rw, input logic [4:0] rd, input logic [4:0] wr,
                               input logic [1:0] regdst, input logic wrsrc, input logic srca,
                               input logic srcb, input logic ext, input logic [2:0] aluop,
                               input logic dbsrc, input logic [1:0] pcsrc);
      vec_t v;
      v.op = op; v.z = z; v.s = s; v.lat = lat; v.st = st;
      v.rw = rw; v.rd = rd; v.wr = wr;
      v.regdst = regdst; v.wrsrc = wrsrc; v.srca = srca; v.srcb = srcb; v.ext = ext;
      v.aluop = aluop; v.dbsrc = dbsrc; v.pcsrc = pcsrc;
      return v;
   endfunction

   task automatic cmp(input string nm, input int tag, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s tx%0d: got %0h expected %0h", nm, tag, act, exp);
      end
   endtask

   task automatic check_reset(input int tag);
      cmp("rst_state", tag, 4'(state), 4'd0);
      cmp("rst_PCWre", tag, 4'(PCWre), 4'd0);
      cmp("rst_IRWre", tag, 4'(IRWre), 4'd0);
      cmp("rst_RegWre", tag, 4'(RegWre), 4'd0);
      cmp("rst_nRD", tag, 4'(nRD), 4'd1);
      cmp("rst_nWR", tag, 4'(nWR), 4'd1);
      cmp("rst_RegDst", tag, 4'(RegDst), 4'd0);
      cmp("rst_WrRegDSrc", tag, 4'(WrRegDSrc), 4'd0);
      cmp("rst_ALUSrcA", tag, 4'(ALUSrcA), 4'd0);
      cmp("rst_ALUSrcB", tag, 4'(ALUSrcB), 4'd0);
      cmp("rst_ExtSel", tag, 4'(ExtSel), 4'd0);
      cmp("rst_ALUOp", tag, 4'(ALUOp), 4'd0);
      cmp("rst_DBDataSrc", tag, 4'(DBDataSrc), 4'd0);
      cmp("rst_PCSrc", tag, 4'(PCSrc), 4'd0);
   endtask

   // Drive ncyc cycles of an instruction, starting just after an edge in S_IF.
   task automatic run_instr(input vec_t v, input int tag, input int ncyc);
      $display("tx %0d: opcode=%b zero=%b sign=%b cycles=%0d", tag, v.op, v.z, v.s, ncyc);
      for (int k = 0; k < ncyc; k++) begin
         exp_t e;
         Opcode = v.op; zero = v.z; sign = v.s;
         e.state   = v.st[3*k +: 3];
         e.irwre   = (k == 0);
         e.pcwre   = (k == v.lat - 1);
         e.regwre  = v.rw[k];
         e.nrd     = ~v.rd[k];
         e.nwr     = ~v.wr[k];
         e.chk_sel = (k >= 1);
         e.regdst  = v.regdst; e.wrsrc = v.wrsrc; e.srca = v.srca; e.srcb = v.srcb;
         e.ext     = v.ext; e.aluop = v.aluop; e.dbsrc = v.dbsrc;
         e.chk_pc  = (k == v.lat - 1);
         e.pcsrc   = v.pcsrc;
         e.tag     = tag;
         sb.push_back(e);
         @(posedge CLK); #1;
      end
   endtask

   // Hand-written cycle: strobes and state only
   task automatic push_ctl(input int tag, input logic [2:0] st, input logic pcwre,
                           input logic irwre, input logic regwre, input logic nrd, input logic nwr);
      exp_t e;
      e.state = st; e.pcwre = pcwre; e.irwre = irwre; e.regwre = regwre;
      e.nrd = nrd; e.nwr = nwr; e.chk_sel = 1'b0; e.chk_pc = 1'b0;
      e.regdst = '0; e.wrsrc = 1'b0; e.srca = 1'b0; e.srcb = 1'b0; e.ext = 1'b0;
      e.aluop = '0; e.dbsrc = 1'b0; e.pcsrc = '0; e.tag = tag;
      sb.push_back(e);
   endtask

   // Scoreboard checker: outputs are sampled mid-cycle
   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         cmp("state", mon_e.tag, 4'(state), 4'(mon_e.state));
         cmp("PCWre", mon_e.tag, 4'(PCWre), 4'(mon_e.pcwre));
         cmp("IRWre", mon_e.tag, 4'(IRWre), 4'(mon_e.irwre));
         cmp("RegWre", mon_e.tag, 4'(RegWre), 4'(mon_e.regwre));
         cmp("nRD", mon_e.tag, 4'(nRD), 4'(mon_e.nrd));
         cmp("nWR", mon_e.tag, 4'(nWR), 4'(mon_e.nwr));
         if (mon_e.chk_sel) begin
            cmp("RegDst", mon_e.tag, 4'(RegDst), 4'(mon_e.regdst));
            cmp("WrRegDSrc", mon_e.tag, 4'(WrRegDSrc), 4'(mon_e.wrsrc));
            cmp("ALUSrcA", mon_e.tag, 4'(ALUSrcA), 4'(mon_e.srca));
            cmp("ALUSrcB", mon_e.tag, 4'(ALUSrcB), 4'(mon_e.srcb));
            cmp("ExtSel", mon_e.tag, 4'(ExtSel), 4'(mon_e.ext));
            cmp("ALUOp", mon_e.tag, 4'(ALUOp), 4'(mon_e.aluop));
            cmp("DBDataSrc", mon_e.tag, 4'(DBDataSrc), 4'(mon_e.dbsrc));
         end
         if (mon_e.chk_pc)
            cmp("PCSrc", mon_e.tag, 4'(PCSrc), 4'(mon_e.pcsrc));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int tag;
      vec_t v;
      tag = 0;
      //             op         z  s  lat st      rw        rd        wr        RegDst Wr A  B  Ext ALUOp   DB PCSrc
      vecs.push_back(mk(6'b000000,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b10,1,0,0,0,3'b000,0,2'b00)); // add
      vecs.push_back(mk(6'b000001,1,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b10,1,0,0,0,3'b001,0,2'b00)); // sub
      vecs.push_back(mk(6'b010000,0,1,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b10,1,0,0,0,3'b100,0,2'b00)); // and
      vecs.push_back(mk(6'b011000,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b10,1,1,0,0,3'b010,0,2'b00)); // sll
      vecs.push_back(mk(6'b100111,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b10,1,0,0,0,3'b110,0,2'b00)); // slt
      vecs.push_back(mk(6'b000010,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b01,1,0,1,1,3'b000,0,2'b00)); // addiu
      vecs.push_back(mk(6'b010001,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b01,1,0,1,0,3'b100,0,2'b00)); // andi
      vecs.push_back(mk(6'b010010,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b01,1,0,1,0,3'b011,0,2'b00)); // ori
      vecs.push_back(mk(6'b010011,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b01,1,0,1,0,3'b111,0,2'b00)); // xori
      vecs.push_back(mk(6'b100110,0,0,4,ST_ALU,5'b01000,5'b00000,5'b00000,2'b01,1,0,1,1,3'b110,0,2'b00)); // slti
      vecs.push_back(mk(6'b110001,0,0,5,ST_LW ,5'b10000,5'b01000,5'b00000,2'b01,1,0,1,1,3'b000,1,2'b00)); // lw
      vecs.push_back(mk(6'b110000,0,0,4,ST_SW ,5'b00000,5'b00000,5'b01000,2'b00,1,0,1,1,3'b000,0,2'b00)); // sw
      vecs.push_back(mk(6'b110100,1,0,3,ST_BR ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,1,3'b001,0,2'b01)); // beq taken
      vecs.push_back(mk(6'b110100,0,1,3,ST_BR ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,1,3'b001,0,2'b00)); // beq not taken
      vecs.push_back(mk(6'b110101,0,0,3,ST_BR ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,1,3'b001,0,2'b01)); // bne taken
      vecs.push_back(mk(6'b110101,1,0,3,ST_BR ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,1,3'b001,0,2'b00)); // bne not taken
      vecs.push_back(mk(6'b110110,0,1,3,ST_BR ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,1,3'b001,0,2'b01)); // bltz taken
      vecs.push_back(mk(6'b110110,1,0,3,ST_BR ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,1,3'b001,0,2'b00)); // bltz not taken
      vecs.push_back(mk(6'b111000,0,0,2,ST_J  ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,0,3'b000,0,2'b11)); // j
      vecs.push_back(mk(6'b111001,0,0,2,ST_J  ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,0,3'b000,0,2'b10)); // jr
      vecs.push_back(mk(6'b111010,0,0,2,ST_J  ,5'b00010,5'b00000,5'b00000,2'b00,0,0,0,0,3'b000,0,2'b11)); // jal
      vecs.push_back(mk(6'b101010,0,0,2,ST_J  ,5'b00000,5'b00000,5'b00000,2'b00,1,0,0,0,3'b000,0,2'b00)); // unknown -> NOP

      Reset = 1'b0; Opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
`ifdef CU_STALL_EN
      mem_ready = 1'b1;
`endif
      repeat (2) @(posedge CLK);
      #1;
      check_reset(tag);
      Reset = 1'b1;

      // Table: every instruction class back to back
      foreach (vecs[i]) begin
         tag++;
         run_instr(vecs[i], tag, vecs[i].lat);
      end

      // Reset pulled low in S_MEM of lw, then released
      tag++;
      run_instr(vecs[10], tag, 3);
      #1;
      cmp("lw_mem_state", tag, 4'(state), 4'd3);
      cmp("lw_mem_nRD", tag, 4'(nRD), 4'd0);
      Reset = 1'b0;
      #1;
      check_reset(tag);
      @(posedge CLK); #1;
      check_reset(tag);
      Reset = 1'b1;
      #1;
      cmp("rel_IRWre", tag, 4'(IRWre), 4'd1);
      cmp("rel_state", tag, 4'(state), 4'd0);
      tag++;
      run_instr(vecs[0], tag, vecs[0].lat);

      // halt: parks in S_HALT with PCWre low
      tag++;
      $display("tx %0d: opcode=111111 halt, 22 cycles", tag);
      Opcode = 6'b111111;
      push_ctl(tag, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge CLK); #1;
      push_ctl(tag, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge CLK); #1;
      for (int c = 0; c < 20; c++) begin
         push_ctl(tag, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         @(posedge CLK); #1;
      end
      Reset = 1'b0;
      #1;
      check_reset(tag);
      @(posedge CLK); #1;
      Reset = 1'b1;
      v = vecs[20];   // jal after recovering from halt
      tag++;
      run_instr(v, tag, v.lat);

`ifdef CU_STALL_EN
      // sw with mem_ready low for 3 cycles: nWR held 4 cycles, PCWre only on the last
      tag++;
      $display("tx %0d: opcode=110000 sw with 3 stall cycles", tag);
      Opcode = 6'b110000;
      push_ctl(tag, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge CLK); #1;
      push_ctl(tag, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge CLK); #1;
      push_ctl(tag, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge CLK); #1;
      mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         push_ctl(tag, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         @(posedge CLK); #1;
      end
      mem_ready = 1'b1;
      push_ctl(tag, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge CLK); #1;
      tag++;
      run_instr(vecs[0], tag, vecs[0].lat);
`endif

      @(negedge CLK); #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
